handshake_fifo: RTL and testbench

Synchronous first-in/first-out buffer with valid/ready handshakes on both sides, parameterised in payload width and entry count. It decouples a producer from a consumer in one clock domain. Its main use is as the skid/overflow store behind pipelined slice registers, instantiated there with `DEPTH = 2 × pipeline depth`. No payload is dropped, duplicated or reordered.

---
 rtl/handshake_fifo.sv | 88 ++++++++
 tb/tb_handshake_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo.sv
// Single-clock valid/ready FIFO with DEPTH entries of W bits; any DEPTH >= 1.
// Ready/valid come from registered occupancy only: no flow-through, no full-bypass.
module handshake_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic [W-1:0] input_payload,
    output logic         output_valid,
    input  logic         output_ready,
    output logic [W-1:0] output_payload
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_s;
    logic          pop_s;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    assign input_ready    = (count_q != FULL_CNT) && !rst_n;
    assign output_valid   = (count_q != {CW{1'b0}});
    assign push_s         = input_valid && input_ready;
    assign pop_s          = output_valid && output_ready;
    assign output_payload = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset is active-high despite the port name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= input_payload;
        end
    end

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed and randomized bench for handshake_fifo (W=8, DEPTH=6).
module tb_handshake_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         input_valid = 1'b0;
    logic         input_ready;
    logic [W-1:0] input_payload = 8'h00;
    logic         output_valid;
    logic         output_ready = 1'b0;
    logic [W-1:0] output_payload;

    int nchecks = 0;
    int nerrors = 0;

    handshake_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .input_payload  (input_payload),
        .output_valid   (output_valid),
        .output_ready   (output_ready),
        .output_payload (output_payload)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            nchecks++;
            if (output_valid !== 1'b0) begin
                nerrors++;
                $display("FAIL reset_ovalid cyc=%0d got=%b exp=0", i, output_valid);
            end
            nchecks++;
            if (input_ready !== 1'b0) begin
                nerrors++;
                $display("FAIL reset_iready cyc=%0d got=%b exp=0", i, input_ready);
            end
            step();
        end
        rst_n = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            nchecks++;
            if (input_ready !== 1'b1) begin
                nerrors++;
                $display("FAIL idle_iready cyc=%0d got=%b exp=1", i, input_ready);
            end
            nchecks++;
            if (output_valid !== 1'b0) begin
                nerrors++;
                $display("FAIL idle_ovalid cyc=%0d got=%b exp=0", i, output_valid);
            end
            step();
        end
    endtask

    task automatic fill(input logic [7:0] base);
        output_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            input_valid   = 1'b1;
            input_payload = base + 8'(i);
            nchecks++;
            if (input_ready !== 1'b1) begin
                nerrors++;
                $display("FAIL fill_iready i=%0d got=%b exp=1", i, input_ready);
            end
            step();
        end
        input_valid = 1'b0;
    endtask

    task automatic test_fill();
        fill(8'h10);
        nchecks++;
        if (input_ready !== 1'b0) begin
            nerrors++;
            $display("FAIL full_iready got=%b exp=0", input_ready);
        end
        input_valid   = 1'b1;
        input_payload = 8'h16;
        for (int i = 0; i < 2; i++) begin
            step();
            nchecks++;
            if (input_ready !== 1'b0 || output_valid !== 1'b1) begin
                nerrors++;
                $display("FAIL full_hold i=%0d got ir=%b ov=%b exp ir=0 ov=1", i, input_ready, output_valid);
            end
        end
        input_valid = 1'b0;
    endtask

    task automatic test_drain();
        output_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            nchecks++;
            if (output_valid !== 1'b1 || output_payload !== 8'h10 + 8'(i)) begin
                nerrors++;
                $display("FAIL drain i=%0d got ov=%b data=%h exp ov=1 data=%h",
                         i, output_valid, output_payload, 8'h10 + 8'(i));
            end
            step();
        end
        nchecks++;
        if (output_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL drain_empty got=%b exp=0", output_valid);
        end
        output_ready = 1'b0;
    endtask

    task automatic test_stream();
        output_ready = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) begin
                input_valid   = 1'b1;
                input_payload = 8'h40 + 8'(k);
            end else begin
                input_valid = 1'b0;
            end
            if (k == 0) begin
                nchecks++;
                if (output_valid !== 1'b0) begin
                    nerrors++;
                    $display("FAIL stream_first got ov=%b exp=0", output_valid);
                end
            end else begin
                nchecks++;
                if (output_valid !== 1'b1 || output_payload !== 8'h40 + 8'(k - 1)) begin
                    nerrors++;
                    $display("FAIL stream k=%0d got ov=%b data=%h exp ov=1 data=%h",
                             k, output_valid, output_payload, 8'h40 + 8'(k - 1));
                end
            end
            nchecks++;
            if (input_ready !== 1'b1) begin
                nerrors++;
                $display("FAIL stream_iready k=%0d got=%b exp=1", k, input_ready);
            end
            step();
        end
        nchecks++;
        if (output_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL stream_empty got=%b exp=0", output_valid);
        end
        output_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        fill(8'h80);
        input_valid   = 1'b1;
        input_payload = 8'h99;
        output_ready  = 1'b1;
        nchecks++;
        if (input_ready !== 1'b0 || output_payload !== 8'h80) begin
            nerrors++;
            $display("FAIL fullpop_pre got ir=%b data=%h exp ir=0 data=80", input_ready, output_payload);
        end
        step();
        input_valid  = 1'b0;
        output_ready = 1'b0;
        nchecks++;
        if (input_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL fullpop_iready got=%b exp=1", input_ready);
        end
        for (int i = 0; i < 4; i++) begin
            nchecks++;
            if (output_valid !== 1'b1 || output_payload !== 8'h81) begin
                nerrors++;
                $display("FAIL hold i=%0d got ov=%b data=%h exp ov=1 data=81", i, output_valid, output_payload);
            end
            step();
        end
        output_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nchecks++;
            if (output_valid !== 1'b1 || output_payload !== 8'h81 + 8'(i)) begin
                nerrors++;
                $display("FAIL fullpop_drain i=%0d got ov=%b data=%h exp ov=1 data=%h",
                         i, output_valid, output_payload, 8'h81 + 8'(i));
            end
            step();
        end
        nchecks++;
        if (output_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL fullpop_empty got=%b exp=0 (refused push leaked)", output_valid);
        end
        output_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       push;
        logic       pop;
        for (int c = 0; c < 10000; c++) begin
            if (c == 2500 || c == 5000 || c == 7500) begin
                rst_n = 1'b1;
                #1;
                q.delete();
                nchecks++;
                if (output_valid !== 1'b0 || input_ready !== 1'b0) begin
                    nerrors++;
                    $display("FAIL rnd_reset c=%0d got ov=%b ir=%b exp 0 0", c, output_valid, input_ready);
                end
                input_valid  = 1'b0;
                output_ready = 1'b0;
                step();
                rst_n = 1'b0;
                #1;
            end
            nchecks++;
            if (output_valid !== (q.size() != 0) || input_ready !== (q.size() != DEPTH)) begin
                nerrors++;
                $display("FAIL rnd_flags c=%0d got ov=%b ir=%b exp occupancy=%0d", c, output_valid, input_ready, q.size());
            end
            if (q.size() != 0) begin
                nchecks++;
                if (output_payload !== q[0]) begin
                    nerrors++;
                    $display("FAIL rnd_data c=%0d got=%h exp=%h", c, output_payload, q[0]);
                end
            end
            input_valid   = 1'($urandom_range(1, 0));
            output_ready  = 1'($urandom_range(1, 0));
            input_payload = 8'($urandom);
            push = input_valid && (q.size() != DEPTH);
            pop  = output_ready && (q.size() != 0);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(input_payload);
            step();
        end
        input_valid  = 1'b0;
        output_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
